fetch_queue: RTL and testbench

Front-end fetch stage and instruction buffer directly upstream of the two dispatch units. Reads two 32-bit instruction words per request from a synchronous instruction memory, buffers them in a circular queue, and presents the two oldest entries to dispatch units 1 and 2 in program order. On a ROB flush it discards all buffered and in-flight words and restarts fetch at a redirect PC.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fq_storage.sv | 78 +++++++
 rtl/fetch_queue.sv | 159 +++++++++++++++
 tb/tb_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage / instruction buffer.
//   XLEN          instruction and PC width
//   END_MARKER    instruction word that terminates the program
//   fetch_state_t fetch FSM states
//   fq_entry_t    one queue entry: instruction word plus its PC
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] END_MARKER = 32'h0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Circular instruction buffer with two in-order write ports and two read
// ports that always show the two oldest entries.
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 discard all contents (takes priority over push/pop)
//   wr_cnt, wr_data0/1    number of entries pushed this cycle (0..2), oldest first
//   rd_cnt                number of entries popped this cycle (0..2)
//   rd_data0, rd_data1    entry at head and head+1 (contents only meaningful
//                         when count covers them)
//   count                 occupied entries
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [1:0]               wr_cnt,
    input  fq_entry_t                wr_data0,
    input  fq_entry_t                wr_data1,
    input  logic [1:0]               rd_cnt,
    output fq_entry_t                rd_data0,
    output fq_entry_t                rd_data1,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t      mem [DEPTH];
    logic [AW-1:0]  head_reg;
    logic [AW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic [AW-1:0]  tail_p1;
    fq_entry_t      rd_port [2];

    assign tail_p1 = tail_reg + AW'(1);

    // Storage array carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (wr_cnt != 2'd0) begin
                mem[tail_reg] <= wr_data0;
            end
            if (wr_cnt == 2'd2) begin
                mem[tail_p1] <= wr_data1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (clear) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            head_reg  <= head_reg + AW'(rd_cnt);
            tail_reg  <= tail_reg + AW'(wr_cnt);
            count_reg <= count_reg + CW'(wr_cnt) - CW'(rd_cnt);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx         = head_reg + AW'(gi);
        assign rd_port[gi] = mem[idx];
    end

    assign rd_data0 = rd_port[0];
    assign rd_data1 = rd_port[1];
    assign count    = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage plus instruction buffer feeding dispatch units 1 and 2.
// Requests two words per access from a 1-cycle-latency instruction memory,
// queues them with their PCs and presents the two oldest in program order.
// A flush empties the queue, invalidates any in-flight read via an epoch bit
// and restarts fetch at redirect_pc.
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush, redirect_pc            restart request and target address
//   imem_req, imem_addr           memory request (pair at addr, addr+4)
//   imem_rdata0, imem_rdata1      memory response, one cycle after imem_req
//   dispatch_1_ready/_2_ready     consumers take instr1 / instr2
//   instr1/2, pc1/2, instr1/2_valid  two oldest entries
//   instr_queue_empty             program finished and queue drained
//   count                         occupied entries
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata0,
    input  logic [XLEN-1:0]        imem_rdata1,
    input  logic                   dispatch_1_ready,
    input  logic                   dispatch_2_ready,
    output logic [XLEN-1:0]        instr1,
    output logic [XLEN-1:0]        instr2,
    output logic                   instr1_valid,
    output logic                   instr2_valid,
    output logic [XLEN-1:0]        pc1,
    output logic [XLEN-1:0]        pc2,
    output logic                   instr_queue_empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] req_pc_reg;
    logic            pending_reg;
    logic            tag_reg;
    logic            epoch_reg;

    logic [CW:0]     need;
    logic            credit_ok;
    logic            resp_live;
    logic            end_seen;
    logic [1:0]      wr_cnt;
    logic [1:0]      rd_cnt;
    logic            pop1, pop2;
    fq_entry_t       wr_data0, wr_data1, rd_data0, rd_data1;

    // Room check against registered count: space for everything already
    // in flight plus one more pair. Same-cycle pops are deliberately ignored.
    assign need      = {1'b0, count} + {{(CW-1){1'b0}}, pending_reg, 1'b0} + (CW+1)'(2);
    assign credit_ok = need <= (CW+1)'(DEPTH);

    // A response is used only if it belongs to the current epoch and the
    // program has not already ended (a trailing back-to-back pair is dropped).
    assign resp_live = pending_reg && (tag_reg == epoch_reg) && (state_reg != DONE);

    always_comb begin
        wr_cnt   = 2'd0;
        end_seen = 1'b0;
        if (resp_live) begin
            if (imem_rdata0 == END_MARKER) begin
                end_seen = 1'b1;
            end else if (imem_rdata1 == END_MARKER) begin
                wr_cnt   = 2'd1;
                end_seen = 1'b1;
            end else begin
                wr_cnt   = 2'd2;
            end
        end
    end

    // No request while held in reset or once the end marker has arrived.
    assign imem_req  = rst_n && (state_reg == FETCH) && credit_ok && !end_seen;
    assign imem_addr = pc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (end_seen) state_next = DONE;
                     else if (!credit_ok) state_next = STALL;
            STALL:   if (end_seen) state_next = DONE;
                     else if (credit_ok) state_next = FETCH;
            DONE:    state_next = DONE;
            default: state_next = FETCH;
        endcase
        if (flush) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            req_pc_reg  <= '0;
            pending_reg <= 1'b0;
            tag_reg     <= 1'b0;
            epoch_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= imem_req;
            // Tag carries the epoch at issue; a flush in the same cycle flips
            // epoch_reg, so that request's data is discarded on return.
            tag_reg     <= epoch_reg;
            if (imem_req) begin
                req_pc_reg <= pc_reg;
            end
            if (flush) begin
                pc_reg    <= redirect_pc & ~XLEN'(3);
                epoch_reg <= ~epoch_reg;
            end else if (imem_req) begin
                pc_reg    <= pc_reg + XLEN'(8);
            end
        end
    end

    assign wr_data0 = '{instr: imem_rdata0, pc: req_pc_reg};
    assign wr_data1 = '{instr: imem_rdata1, pc: req_pc_reg + XLEN'(4)};

    // In-order consumption: slot 2 can only go together with slot 1.
    assign pop1   = dispatch_1_ready && instr1_valid;
    assign pop2   = pop1 && dispatch_2_ready && instr2_valid;
    assign rd_cnt = {1'b0, pop1} + {1'b0, pop2};

    fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_cnt   (rd_cnt),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .count    (count)
    );

    assign instr1_valid      = count != '0;
    assign instr2_valid      = count > CW'(1);
    assign instr1            = instr1_valid ? rd_data0.instr : '0;
    assign pc1               = instr1_valid ? rd_data0.pc    : '0;
    assign instr2            = instr2_valid ? rd_data1.instr : '0;
    assign pc2               = instr2_valid ? rd_data1.pc    : '0;
    assign instr_queue_empty = (count == '0) && (state_reg == DONE);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a small instruction
// memory model answering one cycle after each request.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata0;
    logic [31:0] imem_rdata1;
    logic        dispatch_1_ready;
    logic        dispatch_2_ready;
    logic [31:0] instr1, instr2, pc1, pc2;
    logic        instr1_valid, instr2_valid;
    logic        instr_queue_empty;
    logic [3:0]  count;

    logic [31:0] prog [64];
    int          checks;
    int          errors;
    logic [31:0] exp_pc;

    fetch_queue #(
        .DEPTH    (8),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_rdata0       (imem_rdata0),
        .imem_rdata1       (imem_rdata1),
        .dispatch_1_ready  (dispatch_1_ready),
        .dispatch_2_ready  (dispatch_2_ready),
        .instr1            (instr1),
        .instr2            (instr2),
        .instr1_valid      (instr1_valid),
        .instr2_valid      (instr2_valid),
        .pc1               (pc1),
        .pc2               (pc2),
        .instr_queue_empty (instr_queue_empty),
        .count             (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: garbage when no request so stray captures show up.
    always @(posedge clk) begin
        if (imem_req) begin
            imem_rdata0 <= prog[imem_addr[7:2]];
            imem_rdata1 <= prog[imem_addr[7:2] + 6'd1];
        end else begin
            imem_rdata0 <= 32'hFFFF_FFFF;
            imem_rdata1 <= 32'hFFFF_FFFF;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        redirect_pc = '0;
        dispatch_1_ready = 1'b0;
        dispatch_2_ready = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = 32'h00A00093;
        prog[1] = 32'h00B00113;
        prog[2] = 32'h002081B3;
        prog[3] = 32'h40110233;
        prog[4] = 32'h003202B3;
        prog[5] = 32'h00100313;
        // Region 0x20..0x7C encodes its own address; 0x80 is the end marker.
        for (int i = 8; i < 32; i++) prog[i] = 32'h2000_0000 | (i * 4);

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {28'h0, count}, 32'd0);
        check("rst_req", {31'h0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_v1", {31'h0, instr1_valid}, 32'd0);
        check("rst_empty", {31'h0, instr_queue_empty}, 32'd0);

        // ---- first fetch and fill to DONE ----
        rst_n = 1'b1;
        #1;
        check("a_req0", {31'h0, imem_req}, 32'd1);
        check("a_addr0", imem_addr, 32'h0);
        tick();
        check("a_addr1", imem_addr, 32'h8);
        tick();
        check("a_count2", {28'h0, count}, 32'd2);
        check("a_i1", instr1, 32'h00A00093);
        check("a_p1", pc1, 32'h0);
        check("a_i2", instr2, 32'h00B00113);
        check("a_p2", pc2, 32'h4);
        tick();
        tick();
        tick();
        check("a_done_count", {28'h0, count}, 32'd6);
        check("a_done_req", {31'h0, imem_req}, 32'd0);
        check("a_done_empty", {31'h0, instr_queue_empty}, 32'd0);

        // ---- dispatch 2 alone never pops ----
        dispatch_2_ready = 1'b1;
        tick();
        check("d2only_count", {28'h0, count}, 32'd6);
        check("d2only_i1", instr1, 32'h00A00093);

        // ---- drain in order ----
        dispatch_1_ready = 1'b1;
        check("dr0_p1", pc1, 32'h0);
        check("dr0_p2", pc2, 32'h4);
        tick();
        check("dr1_count", {28'h0, count}, 32'd4);
        check("dr1_i1", instr1, 32'h002081B3);
        check("dr1_p1", pc1, 32'h8);
        check("dr1_i2", instr2, 32'h40110233);
        check("dr1_p2", pc2, 32'hC);
        tick();
        check("dr2_i1", instr1, 32'h003202B3);
        check("dr2_p1", pc1, 32'h10);
        check("dr2_i2", instr2, 32'h00100313);
        check("dr2_p2", pc2, 32'h14);
        tick();
        check("dr3_count", {28'h0, count}, 32'd0);
        check("dr3_empty", {31'h0, instr_queue_empty}, 32'd1);
        check("dr3_i1", instr1, 32'h0);
        dispatch_1_ready = 1'b0;
        dispatch_2_ready = 1'b0;
        tick();
        check("dr4_req", {31'h0, imem_req}, 32'd0);

        // ---- redirect to 0x40, fill until stall ----
        flush = 1'b1;
        redirect_pc = 32'h40;
        tick();
        flush = 1'b0;
        check("b_req", {31'h0, imem_req}, 32'd1);
        check("b_addr", imem_addr, 32'h40);
        check("b_count0", {28'h0, count}, 32'd0);
        tick();
        tick();
        tick();
        tick();
        check("b_count6", {28'h0, count}, 32'd6);
        check("b_nocredit", {31'h0, imem_req}, 32'd0);
        tick();
        check("b_full", {28'h0, count}, 32'd8);
        check("b_stall_req", {31'h0, imem_req}, 32'd0);
        dispatch_1_ready = 1'b1;
        dispatch_2_ready = 1'b1;
        check("b_i1", instr1, 32'h2000_0040);
        check("b_p1", pc1, 32'h40);
        check("b_p2", pc2, 32'h44);
        tick();
        dispatch_1_ready = 1'b0;
        dispatch_2_ready = 1'b0;
        check("b_after_pop", {28'h0, count}, 32'd6);
        check("b_still_stall", {31'h0, imem_req}, 32'd0);
        tick();
        check("b_resume_req", {31'h0, imem_req}, 32'd1);
        check("b_resume_addr", imem_addr, 32'h60);
        tick();
        tick();
        check("b_refull", {28'h0, count}, 32'd8);

        // Drain everything; each entry must appear exactly once in order.
        exp_pc = 32'h48;
        dispatch_1_ready = 1'b1;
        dispatch_2_ready = 1'b1;
        for (int n = 0; n < 40 && !instr_queue_empty; n++) begin
            if (instr1_valid) begin
                check("bd_i1", instr1, 32'h2000_0000 | exp_pc);
                check("bd_p1", pc1, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            if (instr2_valid) begin
                check("bd_i2", instr2, 32'h2000_0000 | exp_pc);
                check("bd_p2", pc2, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        dispatch_1_ready = 1'b0;
        dispatch_2_ready = 1'b0;
        check("bd_last_pc", exp_pc, 32'h80);
        check("bd_empty", {31'h0, instr_queue_empty}, 32'd1);

        // ---- flush with a read in flight ----
        flush = 1'b1;
        redirect_pc = 32'h20;
        tick();
        flush = 1'b0;
        check("c_addr20", imem_addr, 32'h20);
        tick();
        flush = 1'b1;
        redirect_pc = 32'h43;
        check("c_req28", {31'h0, imem_req}, 32'd1);
        check("c_addr28", imem_addr, 32'h28);
        tick();
        flush = 1'b0;
        check("c_count_flush", {28'h0, count}, 32'd0);
        check("c_addr40", imem_addr, 32'h40);
        check("c_req40", {31'h0, imem_req}, 32'd1);
        tick();
        check("c_stale_drop", {28'h0, count}, 32'd0);
        tick();
        check("c_count2", {28'h0, count}, 32'd2);
        check("c_i1", instr1, 32'h2000_0040);
        check("c_p1", pc1, 32'h40);

        // ---- end marker in word 0 of the pair at 0x10 ----
        prog[4] = 32'h0;
        prog[5] = 32'hBAD0_0005;
        tick();
        flush = 1'b1;
        redirect_pc = 32'h8;
        tick();
        flush = 1'b0;
        check("d_count0", {28'h0, count}, 32'd0);
        check("d_addr8", imem_addr, 32'h8);
        tick();
        check("d_addr10", imem_addr, 32'h10);
        tick();
        check("d_count2", {28'h0, count}, 32'd2);
        check("d_noreq", {31'h0, imem_req}, 32'd0);
        tick();
        check("d_hold_count", {28'h0, count}, 32'd2);
        check("d_hold_req", {31'h0, imem_req}, 32'd0);
        check("d_i1", instr1, 32'h002081B3);
        check("d_p1", pc1, 32'h8);
        check("d_i2", instr2, 32'h40110233);
        check("d_p2", pc2, 32'hC);
        tick();
        check("d_hold2_count", {28'h0, count}, 32'd2);
        flush = 1'b1;
        redirect_pc = 32'h0;
        tick();
        flush = 1'b0;
        check("d_restart_count", {28'h0, count}, 32'd0);
        check("d_restart_req", {31'h0, imem_req}, 32'd1);
        check("d_restart_addr", imem_addr, 32'h0);

        // ---- reset in the middle of fetching ----
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("e_rst_count", {28'h0, count}, 32'd0);
        check("e_rst_req", {31'h0, imem_req}, 32'd0);
        check("e_rst_addr", imem_addr, 32'h0);
        check("e_rst_v1", {31'h0, instr1_valid}, 32'd0);
        tick();
        check("e_rst_hold", {28'h0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
